case_9_sdiv_8s_6s_8_seq: RTL and testbench

Iterative signed divider, the inverse of the `case_9` signed multiplier datapath. It accepts an 8-bit signed dividend and a 6-bit signed divisor over a valid/ready handshake. It produces an 8-bit signed quotient and a 6-bit signed remainder using C truncating semantics. It computes one quotient bit per cycle with a restoring algorithm and sits in the `case_9` datapath wherever a `/` or `%` operator needs a small, non-pipelined core.

---
 rtl/case_9_div_pkg.sv | 23 ++
 rtl/case_9_div_step.sv | 33 +++
 rtl/case_9_sdiv_8s_6s_8_seq.sv | 154 +++++++++++++++
 tb/tb_case_9_sdiv_8s_6s_8_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/case_9_div_pkg.sv
// Shared constants and state encoding for the case_9 iterative signed divider.
package case_9_div_pkg;

    // Default operand and result widths
    localparam int DIN0_W = 8;
    localparam int DIN1_W = 6;
    localparam int DOUT_W = 8;

    // Iteration counter width: counts 0 .. DIN0_W-1
    localparam int CNT_W = $clog2(DIN0_W);

    // Partial remainder carries one extra bit above the divisor magnitude
    localparam int PR_W = DIN1_W + 1;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/case_9_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor magnitude, keep the difference only when it is non-negative.
import case_9_div_pkg::*;

module case_9_div_step #(
    parameter int DVS_W = DIN1_W,
    parameter int PRW   = DVS_W + 1
) (
    input  logic [PRW-1:0]   pr_in,
    input  logic             dvd_bit,
    input  logic [DVS_W-1:0] dvs,
    output logic [PRW-1:0]   pr_out,
    output logic             q_bit
);

    logic [PRW:0]   shifted;
    logic [PRW+1:0] diff;

    // Shift, trial-subtract and restore in a single combinational step
    always_comb begin
        shifted = {pr_in, dvd_bit};
        diff    = {1'b0, shifted} - {3'b000, dvs};
        // The partial remainder is always below the divisor, so a successful
        // trial never sets the two top bits; both are zero only on success.
        q_bit   = ~|diff[PRW+1:PRW];
        if (q_bit) begin
            pr_out = diff[PRW-1:0];
        end else begin
            pr_out = shifted[PRW-1:0];
        end
    end

endmodule

// File: rtl/case_9_sdiv_8s_6s_8_seq.sv
// Iterative signed divider: magnitudes are divided one quotient bit per cycle
// with a restoring step, then signs are applied so that the quotient rounds
// toward zero and the remainder follows the dividend's sign.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; in_ready/out_valid depend only on state, never on the
// partner's valid/ready, and the result is held stable until it is taken.
import case_9_div_pkg::*;

module case_9_sdiv_8s_6s_8_seq #(
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DOUT_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_by_zero,
    output logic [1:0]            dbg_state
);

    localparam int CW  = $clog2(din0_WIDTH);
    localparam int PRW = din1_WIDTH + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(din0_WIDTH - 1);

    state_e                  state_q, state_d;
    logic [din0_WIDTH-1:0]   dvd_q, dvd_d;     // dividend magnitude, becomes quotient
    logic [din1_WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
    logic [PRW-1:0]          pr_q, pr_d;       // partial remainder
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    sign_q_q, sign_q_d;
    logic                    sign_r_q, sign_r_d;
    logic                    zero_q, zero_d;
    logic [dout_WIDTH-1:0]   quot_q, quot_d;
    logic [din1_WIDTH-1:0]   rem_q, rem_d;
    logic                    dbz_q, dbz_d;

    logic [PRW-1:0]          step_pr;
    logic                    step_q;
    logic [din1_WIDTH-1:0]   r_mag;

    case_9_div_step #(
        .DVS_W (din1_WIDTH),
        .PRW   (PRW)
    ) u_step (
        .pr_in   (pr_q),
        .dvd_bit (dvd_q[din0_WIDTH-1]),
        .dvs     (dvs_q),
        .pr_out  (step_pr),
        .q_bit   (step_q)
    );

    assign r_mag = pr_q[din1_WIDTH-1:0];

    // Next-state and datapath update for all four phases
    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        pr_d     = pr_q;
        cnt_d    = cnt_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        zero_d   = zero_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = CALC;
                    // Magnitudes: the most negative value maps to 2^(W-1), which fits unsigned
                    dvd_d    = din0[din0_WIDTH-1] ? (~din0 + din0_WIDTH'(1)) : din0;
                    dvs_d    = din1[din1_WIDTH-1] ? (~din1 + din1_WIDTH'(1)) : din1;
                    sign_q_d = din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                    sign_r_d = din0[din0_WIDTH-1];
                    zero_d   = (din1 == '0);
                    pr_d     = '0;
                    cnt_d    = '0;
                end
            end
            CALC: begin
                pr_d  = step_pr;
                dvd_d = {dvd_q[din0_WIDTH-2:0], step_q};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                if (zero_q) begin
                    quot_d = '1;
                    rem_d  = '0;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = sign_q_q ? (~dvd_q + dout_WIDTH'(1)) : dvd_q;
                    rem_d  = sign_r_q ? (~r_mag + din1_WIDTH'(1)) : r_mag;
                    dbz_d  = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= IDLE;
            dvd_q    <= '0;
            dvs_q    <= '0;
            pr_q     <= '0;
            cnt_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            zero_q   <= 1'b0;
            quot_q   <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            pr_q     <= pr_d;
            cnt_q    <= cnt_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            zero_q   <= zero_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
        end
    end

    // Handshake flags decode from state only; ready is held low during reset
    assign in_ready    = (state_q == IDLE) & ap_rst_n;
    assign out_valid   = (state_q == DONE);
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_case_9_sdiv_8s_6s_8_seq.sv
// Directed bench for the iterative signed divider plus a randomized sweep
// checked against C truncating division.
module tb_case_9_sdiv_8s_6s_8_seq;

    logic       ap_clk    = 1'b0;
    logic       ap_rst_n  = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] din0      = '0;
    logic [5:0] din1      = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] quot;
    logic [5:0] rem;
    logic       div_by_zero;
    logic [1:0] dbg_state;

    int cyc        = 0;
    int accept_cyc = 0;
    int pass_cnt   = 0;
    int chk_cnt    = 0;

    case_9_sdiv_8s_6s_8_seq dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .din0        (din0),
        .din1        (din1),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // Clock and cycle counter
    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present operands and complete the input handshake on the next edge
    task automatic start_op(input logic [7:0] a, input logic [5:0] b);
        @(negedge ap_clk);
        din0     = a;
        din1     = b;
        in_valid = 1'b1;
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge ap_clk);
        #1;
        accept_cyc = cyc;
        in_valid   = 1'b0;
    endtask

    // Wait (bounded) for out_valid and check latency from the accepting edge
    task automatic wait_done(input string tag);
        while (!out_valid && (cyc - accept_cyc) < 40) begin
            @(posedge ap_clk);
            #1;
        end
        check(tag, cyc - accept_cyc, 32'd9);
    endtask

    task automatic check_res(input string tag, input logic [7:0] q, input logic [5:0] r, input logic z);
        check({tag, "_quot"}, {24'd0, quot}, {24'd0, q});
        check({tag, "_rem"}, {26'd0, rem}, {26'd0, r});
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, z});
    endtask

    // Full operation with out_ready held high: DONE lasts one cycle
    task automatic run_op(input string tag, input logic [7:0] a, input logic [5:0] b,
                          input logic [7:0] q, input logic [5:0] r, input logic z);
        start_op(a, b);
        wait_done({tag, "_latency"});
        check_res(tag, q, r, z);
        @(posedge ap_clk);
        #1;
        check({tag, "_done_one_cycle"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_again"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic model(input logic [7:0] a, input logic [5:0] b,
                         output logic [7:0] q, output logic [5:0] r, output logic z);
        int ia;
        int ib;
        int iq;
        int ir;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (ib == 0) begin
            q = 8'hFF;
            r = 6'h00;
            z = 1'b1;
        end else begin
            iq = ia / ib;
            ir = ia % ib;
            q  = iq[7:0];
            r  = ir[5:0];
            z  = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [5:0] rb;
        logic [7:0] eq;
        logic [5:0] er;
        logic       ez;
        logic       saw_valid;

        // Reset state
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_res("rst", 8'h00, 6'h00, 1'b0);
        check("rst_state_idle", {30'd0, dbg_state}, 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors
        run_op("m100_d7",  8'h9C, 6'h07, 8'hF2, 6'h3E, 1'b0);
        run_op("127_dm32", 8'h7F, 6'h20, 8'hFD, 6'h1F, 1'b0);
        run_op("m128_dm1", 8'h80, 6'h3F, 8'h80, 6'h00, 1'b0);
        run_op("45_d0",    8'h2D, 6'h00, 8'hFF, 6'h00, 1'b1);

        // Backpressure: result and DONE held while out_ready is low
        out_ready = 1'b0;
        start_op(8'h32, 6'h05);
        wait_done("bp_latency");
        for (int i = 0; i < 6; i++) begin
            @(posedge ap_clk);
            #1;
            check("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            check_res("bp", 8'h0A, 6'h00, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        check("bp_released", {31'd0, out_valid}, 32'd0);

        // Busy input: a second request during CALC is ignored
        start_op(8'h64, 6'h07);
        @(negedge ap_clk);
        in_valid = 1'b1;
        din0     = 8'h01;
        din1     = 6'h01;
        for (int i = 0; i < 2; i++) begin
            @(negedge ap_clk);
            check("busy_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        wait_done("busy_latency");
        check_res("busy", 8'h0E, 6'h02, 1'b0);
        @(posedge ap_clk);
        #1;

        // Reset in the middle of CALC discards the operation
        start_op(8'hA6, 6'h0B);
        repeat (4) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check_res("midrst", 8'h00, 6'h00, 1'b0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        check("midrst_ready_after_release", {31'd0, in_ready}, 32'd1);
        saw_valid = 1'b0;
        repeat (12) begin
            @(posedge ap_clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("midrst_no_out_valid", {31'd0, saw_valid}, 32'd0);
        run_op("20_d3", 8'h14, 6'h03, 8'h06, 6'h02, 1'b0);

        // Randomized sweep against truncating division
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 6'($urandom_range(0, 63));
            model(ra, rb, eq, er, ez);
            run_op("rand", ra, rb, eq, er, ez);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
